// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port general register file: default geometry,
// the hard-wired zero register index and a packed-bus field extractor.
package gemips_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_BUS_W  = 256;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = DEF_ADDR_W'(0);

  // Returns field k of width w from a packed bus, zero-extended to MAX_BUS_W.
  function automatic logic [MAX_BUS_W-1:0] field_of(input logic [MAX_BUS_W-1:0] bus,
                                                    input int k, input int w);
    logic [MAX_BUS_W-1:0] mask;
    mask = (MAX_BUS_W'(1) << w) - MAX_BUS_W'(1);
    return (bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, the issue-time alloc port,
// NUM_RD read ports and the pending scoreboard vector.
interface regfile_mp_if
  import gemips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  logic                       we0;
  logic [ADDR_W-1:0]          waddr0;
  logic [DATA_W-1:0]          wdata0;
  logic                       we1;
  logic [ADDR_W-1:0]          waddr1;
  logic [DATA_W-1:0]          wdata1;
  logic                       alloc_en;
  logic [ADDR_W-1:0]          alloc_addr;
  logic [NUM_RD-1:0]          re;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  // rvalid[k] is a status flag, not a handshake: high means rdata slice k is
  // architecturally current; low with re[k] high means a RAW hazard on that read.
  logic [NUM_RD-1:0]          rvalid;
  logic [(2**ADDR_W)-1:0]     pending;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, alloc_en, alloc_addr, re, raddr,
    input  rdata, rvalid, pending
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, alloc_en, alloc_addr, re, raddr,
    output rdata, rvalid, pending
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set when a producer issues, cleared on writeback.
// A same-cycle alloc beats a writeback because the new producer is younger.
module regfile_scoreboard
  import gemips_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [ADDR_W-1:0]      alloc_addr,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      waddr0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      waddr1,
  output logic [(2**ADDR_W)-1:0] pending
);

  localparam int NREG = 2**ADDR_W;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (alloc_en && alloc_addr == ADDR_W'(r)) begin
          pending[r] <= 1'b1;
        end else if ((we0 && waddr0 == ADDR_W'(r)) || (we1 && waddr1 == ADDR_W'(r))) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised ID-stage register file: dual write ports (port 1 wins), per-port
// write-to-read bypass, pending scoreboard and optional registered read outputs.
module regfile_mp
  import gemips_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int READ_REG = 0
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int                NREG   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .we0        (bus.we0),
    .waddr0     (bus.waddr0),
    .we1        (bus.we1),
    .waddr1     (bus.waddr1),
    .pending    (bus.pending)
  );

  // Port 1 is written last so it overrides port 0 on an address clash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (bus.we0 && bus.waddr0 != ZERO_A) regs[bus.waddr0] <= bus.wdata0;
      if (bus.we1 && bus.waddr1 != ZERO_A) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              v;

    always_comb begin
      ra = ADDR_W'(field_of(MAX_BUS_W'(bus.raddr), k, ADDR_W));
      d  = '0;
      v  = 1'b0;
      if (rst && bus.re[k]) begin
        if (ra == ZERO_A) begin
          v = 1'b1;
        end else if (bus.we1 && bus.waddr1 == ra) begin
          d = bus.wdata1;
          v = 1'b1;
        end else if (bus.we0 && bus.waddr0 == ra) begin
          d = bus.wdata0;
          v = 1'b1;
        end else begin
          // Stale data is still returned while the register is pending.
          d = regs[ra];
          v = !bus.pending[ra];
        end
      end
    end

    if (READ_REG != 0) begin : g_q
      logic [DATA_W-1:0] d_q;
      logic              v_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else begin
          d_q <= d;
          v_q <= v;
        end
      end

      assign bus.rdata[k*DATA_W +: DATA_W] = d_q;
      assign bus.rvalid[k]                 = v_q;
    end else begin : g_c
      assign bus.rdata[k*DATA_W +: DATA_W] = d;
      assign bus.rvalid[k]                 = v;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a combinational 2-port build and a registered 4-port build
// share the same write/alloc stimulus and are both checked against one array model.
module tb_regfile_mp;
  import gemips_regfile_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR_A = 2;
  localparam int NR_B = 4;
  localparam int NREG = 32;
  localparam int QW   = NR_B*DW + NR_B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 we0, we1, alloc_en;
  logic [AW-1:0]        waddr0, waddr1, alloc_addr;
  logic [DW-1:0]        wdata0, wdata1;
  logic [NR_A-1:0]      re_a;
  logic [NR_A*AW-1:0]   raddr_a;
  logic [NR_B-1:0]      re_b;
  logic [NR_B*AW-1:0]   raddr_b;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR_A)) ifa ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR_B)) ifb ();

  assign ifa.we0 = we0;           assign ifb.we0 = we0;
  assign ifa.waddr0 = waddr0;     assign ifb.waddr0 = waddr0;
  assign ifa.wdata0 = wdata0;     assign ifb.wdata0 = wdata0;
  assign ifa.we1 = we1;           assign ifb.we1 = we1;
  assign ifa.waddr1 = waddr1;     assign ifb.waddr1 = waddr1;
  assign ifa.wdata1 = wdata1;     assign ifb.wdata1 = wdata1;
  assign ifa.alloc_en = alloc_en; assign ifb.alloc_en = alloc_en;
  assign ifa.alloc_addr = alloc_addr; assign ifb.alloc_addr = alloc_addr;
  assign ifa.re = re_a;           assign ifb.re = re_b;
  assign ifa.raddr = raddr_a;     assign ifb.raddr = raddr_b;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR_A), .READ_REG(0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR_B), .READ_REG(1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]   m_regs [NREG];
  logic [NREG-1:0] m_pend;
  logic [QW-1:0]   exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_regs[r] = '0;
    m_pend = '0;
    exp_q.delete();
  endtask

  // {valid, data} a read port should present this cycle.
  function automatic logic [DW:0] model_read(input logic en, input logic [AW-1:0] a);
    if (!rst || !en) return '0;
    if (a == 0) return {1'b1, {DW{1'b0}}};
    if (we1 && waddr1 == a) return {1'b1, wdata1};
    if (we0 && waddr0 == a) return {1'b1, wdata0};
    return {~m_pend[a], m_regs[a]};
  endfunction

  task automatic model_commit();
    logic [NREG-1:0] wr_mask;
    wr_mask = '0;
    if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; wr_mask[waddr0] = 1'b1; end
    if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; wr_mask[waddr1] = 1'b1; end
    m_pend = m_pend & ~wr_mask;
    if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    alloc_en = 0; alloc_addr = '0;
    re_a = '0; raddr_a = '0; re_b = '0; raddr_b = '0;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic pre_check();
    logic [DW:0]   r;
    logic [QW-1:0] e;
    #1;
    for (int k = 0; k < NR_A; k++) begin
      r = model_read(re_a[k], raddr_a[k*AW +: AW]);
      chk($sformatf("a_rdata%0d", k), 128'(ifa.rdata[k*DW +: DW]), 128'(r[DW-1:0]));
      chk($sformatf("a_rvalid%0d", k), 128'(ifa.rvalid[k]), 128'(r[DW]));
    end
    chk("a_pending", 128'(ifa.pending), 128'(m_pend));
    chk("b_pending", 128'(ifb.pending), 128'(m_pend));
    e = '0;
    for (int k = 0; k < NR_B; k++) begin
      r = model_read(re_b[k], raddr_b[k*AW +: AW]);
      e[k*DW +: DW]   = r[DW-1:0];
      e[NR_B*DW + k]  = r[DW];
    end
    exp_q.push_back(e);
  endtask

  task automatic post_edge();
    logic [QW-1:0] e;
    @(posedge clk);
    model_commit();
    #1;
    e = exp_q.pop_front();
    chk("b_rdata", 128'(ifb.rdata), 128'(e[NR_B*DW-1:0]));
    chk("b_rvalid", 128'(ifb.rvalid), 128'(e[QW-1:NR_B*DW]));
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle with a write and alloc in flight; checks outputs clear at once.
  task automatic do_reset();
    we0 = 1; waddr0 = 5'd6; wdata0 = 32'hBAD0BAD0;
    alloc_en = 1; alloc_addr = 5'd6;
    #2 rst = 1'b0;
    #1;
    chk("rst_a_rdata", 128'(ifa.rdata), 128'(0));
    chk("rst_a_rvalid", 128'(ifa.rvalid), 128'(0));
    chk("rst_a_pending", 128'(ifa.pending), 128'(0));
    chk("rst_b_rdata", 128'(ifb.rdata), 128'(0));
    chk("rst_b_rvalid", 128'(ifb.rvalid), 128'(0));
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_hold_b_rdata", 128'(ifb.rdata), 128'(0));
    chk("rst_hold_pending", 128'(ifb.pending), 128'(0));
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          al;
    logic [AW-1:0] aa;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [1:0]    rv;
    logic [NREG-1:0] pend;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input int we0_i, input int wa0, input logic [31:0] wd0,
                              input int we1_i, input int wa1, input logic [31:0] wd1,
                              input int al, input int aa, input int re, input int ra0,
                              input int ra1, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int rv, input int pend);
    vec_t v;
    v.we0 = 1'(we0_i); v.wa0 = AW'(wa0); v.wd0 = wd0;
    v.we1 = 1'(we1_i); v.wa1 = AW'(wa1); v.wd1 = wd1;
    v.al = 1'(al); v.aa = AW'(aa); v.re = 2'(re);
    v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.rd0 = rd0; v.rd1 = rd1; v.rv = 2'(rv); v.pend = NREG'(pend);
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    logic [NR_B*DW-1:0] exp_b;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // warm up with random traffic so the reset below has state to discard
    for (int n = 0; n < 20; n++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
      we1 = 1'($urandom_range(0, 1)); waddr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
      alloc_en = 1'($urandom_range(0, 1)); alloc_addr = AW'($urandom_range(0, 15));
      pre_check();
      post_edge();
    end
    do_reset();

    vecs[0]  = mk(0,0,32'h0,        0,0,32'h0,  0,0, 3, 0,3, 32'h0,        32'h0,        3, 0);
    vecs[1]  = mk(1,5,32'hDEADBEEF, 0,0,32'h0,  0,0, 0, 0,0, 32'h0,        32'h0,        0, 0);
    vecs[2]  = mk(1,0,32'h1,        0,0,32'h0,  0,0, 1, 5,0, 32'hDEADBEEF, 32'h0,        1, 0);
    vecs[3]  = mk(0,0,32'h0,        0,0,32'h0,  0,0, 3, 0,5, 32'h0,        32'hDEADBEEF, 3, 0);
    vecs[4]  = mk(1,7,32'h11,       1,7,32'h22, 0,0, 1, 7,0, 32'h22,       32'h0,        1, 0);
    vecs[5]  = mk(0,0,32'h0,        0,0,32'h0,  0,0, 3, 7,7, 32'h22,       32'h22,       3, 0);
    vecs[6]  = mk(0,0,32'h0,        0,0,32'h0,  1,9, 1, 9,0, 32'h0,        32'h0,        1, 0);
    vecs[7]  = mk(0,0,32'h0,        0,0,32'h0,  0,0, 3, 9,9, 32'h0,        32'h0,        0, 1<<9);
    vecs[8]  = mk(0,0,32'h0,        1,9,32'h55, 0,0, 1, 9,0, 32'h55,       32'h0,        1, 1<<9);
    vecs[9]  = mk(0,0,32'h0,        0,0,32'h0,  0,0, 1, 9,0, 32'h55,       32'h0,        1, 0);
    vecs[10] = mk(0,0,32'h0,        1,4,32'h44, 1,4, 0, 0,0, 32'h0,        32'h0,        0, 0);
    vecs[11] = mk(0,0,32'h0,        0,0,32'h0,  0,0, 1, 4,0, 32'h44,       32'h0,        0, 1<<4);
    vecs[12] = mk(1,4,32'h77,       0,0,32'h0,  1,0, 3, 4,4, 32'h77,       32'h77,       3, 1<<4);
    vecs[13] = mk(0,0,32'h0,        0,0,32'h0,  0,0, 3, 4,5, 32'h77,       32'hDEADBEEF, 3, 0);

    for (int i = 0; i < 14; i++) begin
      we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      alloc_en = vecs[i].al; alloc_addr = vecs[i].aa;
      re_a = vecs[i].re; raddr_a = {vecs[i].ra1, vecs[i].ra0};
      re_b = '0; raddr_b = '0;
      pre_check();
      chk($sformatf("vec%0d_rdata0", i), 128'(ifa.rdata[DW-1:0]), 128'(vecs[i].rd0));
      chk($sformatf("vec%0d_rdata1", i), 128'(ifa.rdata[2*DW-1:DW]), 128'(vecs[i].rd1));
      chk($sformatf("vec%0d_rvalid", i), 128'(ifa.rvalid), 128'(vecs[i].rv));
      chk($sformatf("vec%0d_pending", i), 128'(ifa.pending), 128'(vecs[i].pend));
      post_edge();
    end

    // registered 4-port build: load regs 1..4, then one-cycle-latency read
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      we1 = 1; waddr1 = AW'(i); wdata1 = 32'hA0 + DW'(i);
      pre_check();
      post_edge();
    end
    idle_inputs();
    re_b = 4'hF; raddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
    pre_check();
    chk("rr_before_rvalid", 128'(ifb.rvalid), 128'(0));
    chk("rr_before_rdata", 128'(ifb.rdata), 128'(0));
    post_edge();
    exp_b = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    chk("rr_after_rdata", 128'(ifb.rdata), 128'(exp_b));
    chk("rr_after_rvalid", 128'(ifb.rvalid), 128'(4'hF));
    re_b = '0;
    pre_check();
    chk("rr_hold_rdata", 128'(ifb.rdata), 128'(exp_b));
    post_edge();
    chk("rr_drop_rvalid", 128'(ifb.rvalid), 128'(0));
    chk("rr_drop_rdata", 128'(ifb.rdata), 128'(0));

    // load the registered outputs, then reset asynchronously between edges
    re_b = 4'hF; raddr_b = {5'd1, 5'd2, 5'd3, 5'd4};
    pre_check();
    post_edge();
    chk("rr_loaded_rvalid", 128'(ifb.rvalid), 128'(4'hF));
    re_b = '0;
    do_reset();

    // randomized traffic, addresses kept narrow to provoke clashes and bypasses
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
      we1 = 1'($urandom_range(0, 1)); waddr1 = AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
      alloc_en = ($urandom_range(0, 2) == 0); alloc_addr = AW'($urandom_range(0, 7));
      re_a = NR_A'($urandom); re_b = NR_B'($urandom);
      for (int k = 0; k < NR_A; k++) raddr_a[k*AW +: AW] = AW'($urandom_range(0, 7));
      for (int k = 0; k < NR_B; k++) raddr_b[k*AW +: AW] = AW'($urandom_range(0, 7));
      pre_check();
      post_edge();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
